// File: rtl/tile_board.sv
// ============================================================================
// Module  : tile_board
// Brief   : Tile Flip game board. Latches a 16-tile layout, reveals player
//           selections in pairs, detects matches, hides mismatches after a
//           hold time and flags a win. Optional move limit with a LOST state
//           is enabled by defining TILE_BOARD_MOVE_LIMIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_board #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MOVE_W      = 8,
    parameter int MAX_MOVES   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [47:0]       tile_setup,
    input  logic              sel_valid,
    input  logic [3:0]        sel_idx,
    output logic              sel_ready,
    output logic [15:0]       face_up,
    output logic [15:0]       matched,
    output logic [47:0]       board,
    output logic              match_pulse,
    output logic              mismatch_pulse,
    output logic              sel_err,
    output logic [MOVE_W-1:0] moves,
    output logic              game_won,
    output logic              game_lost
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_FIRST  = 3'd1,
        S_WAIT_SECOND = 3'd2,
        S_SHOW        = 3'd3,
        S_WON         = 3'd4,
        S_LOST        = 3'd5
    } state_t;

    state_t              r_state;
    logic [47:0]         r_board;
    logic [15:0]         r_face_up;
    logic [15:0]         r_matched;
    logic [MOVE_W-1:0]   r_moves;
    logic [3:0]          r_pairs;
    logic [c_HOLD_W-1:0] r_hold;
    logic [3:0]          r_first_idx;
    logic [3:0]          r_second_idx;
    logic                r_sel_ready;
    logic                r_match_pulse;
    logic                r_mismatch_pulse;
    logic                r_sel_err;
    logic                r_game_won;
    logic                r_game_lost;

    logic [5:0]          w_sel_base;
    logic [5:0]          w_first_base;
    logic [2:0]          w_sel_sym;
    logic [2:0]          w_first_sym;
    logic [15:0]         w_sel_bit;
    logic [15:0]         w_first_bit;
    logic [15:0]         w_second_bit;
    logic                w_sel_free;
    logic [MOVE_W-1:0]   w_moves_next;
    logic                w_limit_hit;

    assign w_sel_base   = {2'b00, sel_idx} * 6'd3;
    assign w_first_base = {2'b00, r_first_idx} * 6'd3;
    assign w_sel_sym    = r_board[w_sel_base +: 3];
    assign w_first_sym  = r_board[w_first_base +: 3];
    assign w_sel_bit    = 16'b1 << sel_idx;
    assign w_first_bit  = 16'b1 << r_first_idx;
    assign w_second_bit = 16'b1 << r_second_idx;
    // Matched tiles stay face-up, so one bit covers "revealed or matched".
    assign w_sel_free   = ~r_face_up[sel_idx];
    assign w_moves_next = (r_moves == {MOVE_W{1'b1}}) ? r_moves : r_moves + 1'b1;

`ifdef TILE_BOARD_MOVE_LIMIT_EN
    assign w_limit_hit = (r_moves == MOVE_W'(MAX_MOVES));
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_board          <= '0;
            r_face_up        <= '0;
            r_matched        <= '0;
            r_moves          <= '0;
            r_pairs          <= '0;
            r_hold           <= '0;
            r_first_idx      <= '0;
            r_second_idx     <= '0;
            r_sel_ready      <= 1'b0;
            r_match_pulse    <= 1'b0;
            r_mismatch_pulse <= 1'b0;
            r_sel_err        <= 1'b0;
            r_game_won       <= 1'b0;
            r_game_lost      <= 1'b0;
        end else begin
            r_match_pulse    <= 1'b0;
            r_mismatch_pulse <= 1'b0;
            r_sel_err        <= 1'b0;
            if (load) begin
                r_board     <= tile_setup;
                r_face_up   <= '0;
                r_matched   <= '0;
                r_moves     <= '0;
                r_pairs     <= '0;
                r_hold      <= '0;
                r_state     <= S_WAIT_FIRST;
                r_sel_ready <= 1'b1;
                r_game_won  <= 1'b0;
                r_game_lost <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_FIRST: begin
                        if (sel_valid) begin
                            if (!w_sel_free) begin
                                r_sel_err <= 1'b1;
                            end else begin
                                r_face_up   <= r_face_up | w_sel_bit;
                                r_first_idx <= sel_idx;
                                r_state     <= S_WAIT_SECOND;
                            end
                        end
                    end
                    S_WAIT_SECOND: begin
                        if (sel_valid) begin
                            if (!w_sel_free) begin
                                r_sel_err <= 1'b1;
                            end else begin
                                r_face_up    <= r_face_up | w_sel_bit;
                                r_second_idx <= sel_idx;
                                r_moves      <= w_moves_next;
                                if (w_sel_sym == w_first_sym) begin
                                    r_matched     <= r_matched | w_sel_bit | w_first_bit;
                                    r_match_pulse <= 1'b1;
                                    r_pairs       <= r_pairs + 4'd1;
                                    if (r_pairs == 4'd7) begin
                                        r_state     <= S_WON;
                                        r_sel_ready <= 1'b0;
                                        r_game_won  <= 1'b1;
                                    end else begin
                                        r_state <= S_WAIT_FIRST;
                                    end
                                end else begin
                                    r_mismatch_pulse <= 1'b1;
                                    r_hold           <= c_HOLD_W'(HOLD_CYCLES - 1);
                                    r_state          <= S_SHOW;
                                    r_sel_ready      <= 1'b0;
                                end
                            end
                        end
                    end
                    S_SHOW: begin
                        if (r_hold == '0) begin
                            // A limit-ending mismatch keeps the pair face-up.
                            if (w_limit_hit) begin
                                r_state     <= S_LOST;
                                r_game_lost <= 1'b1;
                            end else begin
                                r_face_up   <= r_face_up & ~(w_first_bit | w_second_bit);
                                r_state     <= S_WAIT_FIRST;
                                r_sel_ready <= 1'b1;
                            end
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sel_ready      = r_sel_ready;
    assign face_up        = r_face_up;
    assign matched        = r_matched;
    assign board          = r_board;
    assign match_pulse    = r_match_pulse;
    assign mismatch_pulse = r_mismatch_pulse;
    assign sel_err        = r_sel_err;
    assign moves          = r_moves;
    assign game_won       = r_game_won;
    assign game_lost      = r_game_lost;

endmodule

`default_nettype wire

// File: tb/tb_tile_board.sv
// ============================================================================
// Module  : tb_tile_board
// Brief   : Self-checking bench for tile_board: directed game scenarios plus
//           randomized play against a behavioural game model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_board;

    localparam int          HOLD   = 4;
    localparam int          MW     = 8;
    localparam int          MAXM   = 2;
    localparam logic [47:0] LEVEL0 = 48'h053977053977;
`ifdef TILE_BOARD_MOVE_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [47:0]   tile_setup = '0;
    logic          sel_valid = 1'b0;
    logic [3:0]    sel_idx = '0;
    logic          sel_ready;
    logic [15:0]   face_up;
    logic [15:0]   matched;
    logic [47:0]   board;
    logic          match_pulse;
    logic          mismatch_pulse;
    logic          sel_err;
    logic [MW-1:0] moves;
    logic          game_won;
    logic          game_lost;

    int checks = 0;
    int errors = 0;

    tile_board #(.HOLD_CYCLES(HOLD), .MOVE_W(MW), .MAX_MOVES(MAXM)) dut (
        .clk(clk), .reset(reset), .load(load), .tile_setup(tile_setup),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready),
        .face_up(face_up), .matched(matched), .board(board),
        .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
        .sel_err(sel_err), .moves(moves), .game_won(game_won),
        .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 idle, 1 first pick, 2 second pick, 3 showing, 4 won, 5 lost
    int       m_phase = 0;
    logic [2:0] m_sym[16];
    bit       m_up[16];
    bit       m_mat[16];
    int       m_moves = 0, m_pairs = 0, m_left = 0, m_first = 0, m_second = 0;
    bit       m_mp = 0, m_mmp = 0, m_err = 0;

    function automatic logic [15:0] pack_up();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_up[i];
        return v;
    endfunction

    function automatic logic [15:0] pack_mat();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_mat[i];
        return v;
    endfunction

    function automatic logic [47:0] pack_board();
        logic [47:0] v = '0;
        for (int i = 0; i < 16; i++) v[3*i +: 3] = m_sym[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit ld, input logic [47:0] setup,
                              input bit sv, input int idx);
        m_mp = 0; m_mmp = 0; m_err = 0;
        if (r) begin
            m_phase = 0; m_moves = 0; m_pairs = 0; m_left = 0;
            for (int i = 0; i < 16; i++) begin m_sym[i] = 3'd0; m_up[i] = 0; m_mat[i] = 0; end
        end else if (ld) begin
            m_phase = 1; m_moves = 0; m_pairs = 0;
            for (int i = 0; i < 16; i++) begin m_sym[i] = setup[3*i +: 3]; m_up[i] = 0; m_mat[i] = 0; end
        end else if (m_phase == 1 && sv) begin
            if (m_up[idx]) m_err = 1;
            else begin m_up[idx] = 1; m_first = idx; m_phase = 2; end
        end else if (m_phase == 2 && sv) begin
            if (m_up[idx]) m_err = 1;
            else begin
                m_up[idx] = 1; m_second = idx;
                if (m_moves < (1 << MW) - 1) m_moves++;
                if (m_sym[idx] == m_sym[m_first]) begin
                    m_mat[idx] = 1; m_mat[m_first] = 1; m_mp = 1; m_pairs++;
                    m_phase = (m_pairs == 8) ? 4 : 1;
                end else begin
                    m_mmp = 1; m_left = HOLD; m_phase = 3;
                end
            end
        end else if (m_phase == 3) begin
            m_left--;
            if (m_left == 0) begin
                if (LIMIT && m_moves == MAXM) m_phase = 5;
                else begin m_up[m_first] = 0; m_up[m_second] = 0; m_phase = 1; end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [47:0] setup,
                       input bit sv, input logic [3:0] idx);
        reset = r; load = ld; tile_setup = setup; sel_valid = sv; sel_idx = idx;
        @(posedge clk);
        model_step(r, ld, setup, sv, int'(idx));
        #1;
        reset = 0; load = 0; sel_valid = 0;
    endtask

    task automatic sel(input logic [3:0] idx);
        cyc(0, 0, '0, 1, idx);
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 4'd0);
    endtask

    task automatic do_load(input logic [47:0] setup);
        cyc(0, 1, setup, 0, 4'd0);
    endtask

    task automatic test_reset();
        cyc(1, 0, '0, 0, 4'd0);
        cyc(1, 0, '0, 0, 4'd0);
        checks++; if (face_up !== 16'h0) begin errors++; $display("FAIL reset_face_up got %h want 0000", face_up); end
        checks++; if (matched !== 16'h0) begin errors++; $display("FAIL reset_matched got %h want 0000", matched); end
        checks++; if (moves !== '0) begin errors++; $display("FAIL reset_moves got %0d want 0", moves); end
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL reset_sel_ready got %b want 0", sel_ready); end
        checks++; if ({match_pulse, mismatch_pulse, sel_err, game_won, game_lost} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {match_pulse, mismatch_pulse, sel_err, game_won, game_lost}); end
        checks++; if (board !== 48'h0) begin errors++; $display("FAIL reset_board got %h want 0", board); end
    endtask

    task automatic test_match();
        do_load(LEVEL0);
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL load_sel_ready got %b want 1", sel_ready); end
        checks++; if (board !== LEVEL0) begin errors++; $display("FAIL load_board got %h want %h", board, LEVEL0); end
        sel(0);
        sel(8);
        checks++; if (match_pulse !== 1'b1) begin errors++; $display("FAIL match_pulse got %b want 1", match_pulse); end
        checks++; if (matched !== 16'h0101) begin errors++; $display("FAIL match_matched got %h want 0101", matched); end
        checks++; if (face_up !== 16'h0101) begin errors++; $display("FAIL match_face_up got %h want 0101", face_up); end
        checks++; if (moves !== 8'd1) begin errors++; $display("FAIL match_moves got %0d want 1", moves); end
        idle();
        checks++; if (match_pulse !== 1'b0) begin errors++; $display("FAIL match_pulse_len got %b want 0", match_pulse); end
    endtask

    task automatic test_mismatch_hold();
        do_load(LEVEL0);
        sel(0);
        sel(1);
        checks++; if (mismatch_pulse !== 1'b1) begin errors++; $display("FAIL mismatch_pulse got %b want 1", mismatch_pulse); end
        for (int k = 0; k < HOLD; k++) begin
            if (k > 0) sel(4'd5);
            checks++; if (face_up !== 16'h0003) begin errors++; $display("FAIL show_face_up cyc %0d got %h want 0003", k, face_up); end
            checks++; if (sel_ready !== 1'b0 || sel_err !== 1'b0) begin
                errors++; $display("FAIL show_ready_err cyc %0d got %b%b want 00", k, sel_ready, sel_err); end
        end
        idle();
        checks++; if (face_up !== 16'h0000) begin errors++; $display("FAIL show_hide got %h want 0000", face_up); end
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL show_exit_ready got %b want 1", sel_ready); end
    endtask

    task automatic test_sel_err();
        do_load(LEVEL0);
        sel(3);
        sel(3);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_same got %b want 1", sel_err); end
        checks++; if (face_up !== 16'h0008 || moves !== 8'd0) begin
            errors++; $display("FAIL err_same_state got %h/%0d want 0008/0", face_up, moves); end
        sel(11);
        checks++; if (matched !== 16'h0808) begin errors++; $display("FAIL err_pair got %h want 0808", matched); end
        sel(3);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_matched got %b want 1", sel_err); end
        checks++; if (face_up !== 16'h0808 || moves !== 8'd1) begin
            errors++; $display("FAIL err_matched_state got %h/%0d want 0808/1", face_up, moves); end
    endtask

    task automatic test_win();
        do_load(LEVEL0);
        for (int i = 0; i < 8; i++) begin
            sel(4'(i));
            sel(4'(i + 8));
        end
        checks++; if (game_won !== 1'b1) begin errors++; $display("FAIL win_flag got %b want 1", game_won); end
        checks++; if (moves !== 8'd8) begin errors++; $display("FAIL win_moves got %0d want 8", moves); end
        checks++; if (matched !== 16'hFFFF) begin errors++; $display("FAIL win_matched got %h want FFFF", matched); end
        checks++; if (sel_ready !== 1'b0 || game_lost !== 1'b0) begin
            errors++; $display("FAIL win_ready_lost got %b%b want 00", sel_ready, game_lost); end
        sel(0);
        checks++; if (sel_err !== 1'b0 || game_won !== 1'b1) begin
            errors++; $display("FAIL win_sel_ignored got err %b won %b want 0 1", sel_err, game_won); end
        do_load(LEVEL0);
        checks++; if (matched !== 16'h0 || face_up !== 16'h0 || moves !== 8'd0 || game_won !== 1'b0) begin
            errors++; $display("FAIL win_reload got %h %h %0d %b want 0000 0000 0 0", matched, face_up, moves, game_won); end
    endtask

    task automatic test_reset_mid_show();
        do_load(LEVEL0);
        sel(0);
        sel(1);
        idle();
        cyc(1, 0, '0, 1, 4'd2);
        checks++; if (face_up !== 16'h0 || board !== 48'h0 || moves !== 8'd0 || sel_ready !== 1'b0) begin
            errors++; $display("FAIL rst_show got %h %h %0d %b want 0 0 0 0", face_up, board, moves, sel_ready); end
        idle();
        checks++; if (mismatch_pulse !== 1'b0 || face_up !== 16'h0) begin
            errors++; $display("FAIL rst_show_after got %b %h want 0 0000", mismatch_pulse, face_up); end
        sel(4);
        checks++; if (sel_err !== 1'b0 || face_up !== 16'h0) begin
            errors++; $display("FAIL idle_sel got %b %h want 0 0000", sel_err, face_up); end
    endtask

`ifdef TILE_BOARD_MOVE_LIMIT_EN
    task automatic test_lost();
        do_load(LEVEL0);
        sel(0); sel(1);
        for (int k = 0; k < HOLD; k++) idle();
        sel(0); sel(2);
        for (int k = 0; k < HOLD; k++) idle();
        checks++; if (game_lost !== 1'b1) begin errors++; $display("FAIL lost_flag got %b want 1", game_lost); end
        checks++; if (face_up !== 16'h0005 || sel_ready !== 1'b0) begin
            errors++; $display("FAIL lost_state got %h %b want 0005 0", face_up, sel_ready); end
        sel(9);
        checks++; if (face_up !== 16'h0005 || sel_err !== 1'b0) begin
            errors++; $display("FAIL lost_sel got %h %b want 0005 0", face_up, sel_err); end
    endtask
`endif

    task automatic rand_layout(output logic [47:0] setup);
        int sy[16];
        for (int i = 0; i < 16; i++) sy[i] = i / 2;
        for (int i = 15; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            int t = sy[i]; sy[i] = sy[j]; sy[j] = t;
        end
        for (int i = 0; i < 16; i++) setup[3*i +: 3] = 3'(sy[i]);
    endtask

    task automatic test_random();
        logic [47:0] setup;
        rand_layout(setup);
        do_load(setup);
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(99, 0);
            if (r < 2) begin
                rand_layout(setup);
                do_load(setup);
            end else if (r < 3) begin
                cyc(1, 0, '0, 1, 4'($urandom_range(15, 0)));
            end else if (r < 5 && m_phase == 0) begin
                rand_layout(setup);
                do_load(setup);
            end else if (m_phase == 2 && r < 40) begin
                int p = 0;
                for (int j = 0; j < 16; j++)
                    if (j != m_first && m_sym[j] == m_sym[m_first]) p = j;
                sel(4'(p));
            end else begin
                cyc(0, 0, '0, ($urandom_range(9, 0) < 7), 4'($urandom_range(15, 0)));
            end
            checks++; if (face_up !== pack_up()) begin errors++; $display("FAIL rnd_face_up n %0d got %h want %h", n, face_up, pack_up()); end
            checks++; if (matched !== pack_mat()) begin errors++; $display("FAIL rnd_matched n %0d got %h want %h", n, matched, pack_mat()); end
            checks++; if (board !== pack_board()) begin errors++; $display("FAIL rnd_board n %0d got %h want %h", n, board, pack_board()); end
            checks++; if (moves !== MW'(m_moves)) begin errors++; $display("FAIL rnd_moves n %0d got %0d want %0d", n, moves, m_moves); end
            checks++; if ({match_pulse, mismatch_pulse, sel_err} !== {m_mp, m_mmp, m_err}) begin
                errors++; $display("FAIL rnd_pulses n %0d got %b%b%b want %b%b%b", n, match_pulse, mismatch_pulse, sel_err, m_mp, m_mmp, m_err); end
            checks++; if ({sel_ready, game_won, game_lost} !== {(m_phase == 1 || m_phase == 2), (m_phase == 4), (m_phase == 5)}) begin
                errors++; $display("FAIL rnd_status n %0d got %b%b%b phase %0d", n, sel_ready, game_won, game_lost, m_phase); end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch_hold();
        test_sel_err();
        test_win();
        test_reset_mid_show();
`ifdef TILE_BOARD_MOVE_LIMIT_EN
        test_lost();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
